// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32 front end.
//   fetch_state_t    : fetch FSM encoding (IDLE, FETCH, SQUASH)
//   NOP_INST         : addi x0,x0,0, shown to the decoder when nothing is buffered
//   RESET_PC_DEFAULT : default first fetch address
//   word_align()     : clears the byte-offset bits of an address
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SQUASH
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs between the fetch
// request logic and the decoder.
//   clk, nrst   : clock, asynchronous active-low reset
//   push, data  : write an entry (accepted when not full, or when popping)
//   pop         : drop the head entry (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop
//   full, empty : occupancy flags
//   count       : number of valid entries
//   head        : oldest entry, {pc, inst}
module fetch_fifo #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic [63:0]   data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [63:0]   head
);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues single-outstanding word
// reads, buffers returned words with their PCs and presents them to the
// decoder one per cycle. Redirects flush buffered and in-flight words.
//   clk, nrst              : clock, asynchronous active-low reset
//   imem_req/addr          : read request, held with a stable address until ack
//   imem_ack/rdata         : request accepted, returned word valid this cycle
//   redirect, redirect_pc  : taken branch/jump pulse and its target
//   dec_ready              : decoder consumes the head this cycle
//   inst_valid, inst, inst_pc : head of the instruction buffer
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   target;
  logic [31:0]   redir_tgt;
  logic          req_open;
  logic          ack_v;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [63:0]   head;

  assign redir_tgt = word_align(redirect_pc);
  assign ack_v     = imem_req && imem_ack;
  assign imem_addr = pc;
  assign push      = (state == FETCH) && ack_v && !redirect;
  assign pop       = inst_valid && dec_ready;

  assign inst_valid = (count != '0);
  assign inst       = empty ? NOP_INST : head[31:0];
  assign inst_pc    = empty ? 32'h0    : head[63:32];

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .data  ({pc, imem_rdata}),
    .pop   (pop),
    .flush (redirect),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        // An open request is never withdrawn, even if the buffer filled.
        imem_req = !full || req_open;
        if (redirect && imem_req && !imem_ack) state_nxt = SQUASH;
      end
      SQUASH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc       <= RESET_PC;
      target   <= RESET_PC;
      req_open <= 1'b0;
    end else begin
      req_open <= imem_req && !imem_ack;
      unique case (state)
        FETCH: begin
          if (redirect) begin
            // With a request still open the address must not move, so the
            // target waits in its own register until the stale ack arrives.
            if (imem_req && !imem_ack) target <= redir_tgt;
            else                       pc     <= redir_tgt;
          end else if (ack_v) begin
            pc <= pc + 32'd4;
          end
        end
        SQUASH: begin
          if (imem_ack)      pc     <= redirect ? redir_tgt : target;
          else if (redirect) target <= redir_tgt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;

  logic        hi_req, hi_ack, hi_valid;
  logic [31:0] hi_addr, hi_rdata, hi_inst, hi_pc;

  int          lat = 0;
  int          wait_cnt;
  int          checks = 0;
  int          errors = 0;
  int          n_pop = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hi_q[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  // Memory model: word = ~address, ack after lat wait cycles.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = ~imem_addr;
  assign hi_ack     = hi_req;
  assign hi_rdata   = ~hi_addr;

  always @(posedge clk or negedge nrst) begin
    if (!nrst)                      wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .nrst(nrst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_hi (
    .clk(clk), .nrst(nrst),
    .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_ack(hi_ack), .imem_rdata(hi_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .dec_ready(1'b1),
    .inst_valid(hi_valid), .inst(hi_inst), .inst_pc(hi_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_pops(input int n, input int budget);
    int target;
    target = n_pop + n;
    for (int i = 0; i < budget && n_pop < target; i++) begin
      @(posedge clk); #1;
    end
    check("pop_budget", 32'(n_pop >= target), 32'd1);
  endtask

  task automatic find_wait1(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (imem_req && wait_cnt == 1) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Scoreboard: each consumed head is compared with the next expected PC.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (nrst) begin
      if (!redirect && inst_valid && dec_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("sb_empty", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", inst_pc, e);
          check("sb_inst", inst, ~e);
        end
      end
      if (hi_valid && hi_q.size() != 0) begin
        e = hi_q.pop_front();
        check("hi_pc", hi_pc, e);
        check("hi_inst", hi_inst, ~e);
      end
      if (prev_hold) check("addr_hold", imem_addr, prev_addr);
      prev_hold = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    int          p0;
    logic [31:0] old_addr;

    nrst        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, NOP_INST);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_hi_addr", hi_addr, 32'hFFFF_FFF8);

    push_stream(32'h0, 64);
    hi_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    @(negedge clk); #1 nrst = 1'b1;

    // Zero-wait streaming
    @(posedge clk); #1;
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", imem_addr, 32'h0);
    check("c1_valid", 32'(inst_valid), 32'd0);
    @(posedge clk); #1;
    check("c2_valid", 32'(inst_valid), 32'd1);
    check("c2_pc", inst_pc, 32'h0);
    p0 = n_pop;
    repeat (8) @(posedge clk);
    #1;
    check("throughput", 32'(n_pop - p0), 32'd8);

    // Decoder stall fills the buffer and withdraws the request
    dec_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(inst_valid), 32'd1);
    dec_ready = 1'b1;
    wait_pops(6, 50);
    check("hi_seen", 32'(hi_q.size()), 32'd0);

    // Slow memory, redirect while a request waits
    lat = 3;
    find_wait1("find_wait_a");
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    old_addr    = imem_addr;
    exp_q.delete();
    push_stream(32'h0000_0100, 64);
    @(posedge clk); #1;
    redirect = 1'b0;
    check("sq_valid", 32'(inst_valid), 32'd0);
    check("sq_req", 32'(imem_req), 32'd1);
    check("sq_addr", imem_addr, old_addr);
    wait_pops(4, 120);

    // Redirect coincident with ack and pop
    lat = 0;
    wait_pops(3, 50);
    check("coinc", 32'({inst_valid, imem_req, imem_ack}), 32'd7);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    exp_q.delete();
    push_stream(32'h0000_0200, 64);
    @(posedge clk); #1;
    redirect = 1'b0;
    check("co_valid", 32'(inst_valid), 32'd0);
    check("co_req", 32'(imem_req), 32'd1);
    check("co_addr", imem_addr, 32'h0000_0200);
    wait_pops(5, 50);

    // Asynchronous reset in the middle of a request
    lat = 3;
    find_wait1("find_wait_b");
    #3 nrst = 1'b0;
    #1;
    check("ar_req", 32'(imem_req), 32'd0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_valid", 32'(inst_valid), 32'd0);
    check("ar_inst", inst, NOP_INST);
    check("ar_pc", inst_pc, 32'h0);
    check("ar_hi_addr", hi_addr, 32'hFFFF_FFF8);
    exp_q.delete();
    push_stream(32'h0, 64);
    hi_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    lat = 0;
    @(negedge clk); #1 nrst = 1'b1;
    wait_pops(6, 50);
    check("hi_seen2", 32'(hi_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
